// File: rtl/ysyx_24100029_axi_pkg.sv
// Shared AXI4 encodings and read-arbiter state type.
package ysyx_24100029_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/ysyx_24100029_rr_pick.sv
// Two-way round-robin picker: purely combinational, one-hot grant.
// On a tie the requester that did not win last time is chosen.
module ysyx_24100029_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24100029_axi_rd_arbiter.sv
// Two-master AXI4 read arbiter, whole-transaction grant with one idle cycle of arbitration.
// No storage: R back-pressure from the owner is passed straight to the slave.
module ysyx_24100029_axi_rd_arbiter
  import ysyx_24100029_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic [ID_WIDTH-1:0]   m0_rid,

  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic [ID_WIDTH-1:0]   m1_rid,

  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic [ID_WIDTH-1:0]   s_rid,

  output logic [1:0]            grant,
  output logic                  busy
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_grant, last_grant_nxt;
  logic [1:0] pick_gnt;
  logic       own_arvalid, own_rready;

  ysyx_24100029_rr_pick u_pick (
    .req  ({m1_arvalid, m0_arvalid}),
    .last (last_grant),
    .gnt  (pick_gnt)
  );

  assign own_arvalid = owner ? m1_arvalid : m0_arvalid;
  assign own_rready  = owner ? m1_rready  : m0_rready;

  // last_grant resets to M1 so that M0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: if (|pick_gnt) begin
        owner_nxt = pick_gnt[1];
        state_nxt = ADDR;
      end
      ADDR: if (own_arvalid && s_arready) begin
        state_nxt      = DATA;
        last_grant_nxt = owner;
      end
      DATA: if (s_rvalid && own_rready && s_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    if (state == ADDR) begin
      s_arvalid  = own_arvalid;
      s_araddr   = owner ? m1_araddr  : m0_araddr;
      s_arid     = owner ? m1_arid    : m0_arid;
      s_arlen    = owner ? m1_arlen   : m0_arlen;
      s_arsize   = owner ? m1_arsize  : m0_arsize;
      s_arburst  = owner ? m1_arburst : m0_arburst;
      m0_arready = !owner && s_arready;
      m1_arready = owner && s_arready;
    end
    if (state == DATA) begin
      s_rready = own_rready;
      if (owner) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rid    = s_rid;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rid    = s_rid;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_ysyx_24100029_axi_rd_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model.
module tb_ysyx_24100029_axi_rd_arbiter;
  import ysyx_24100029_axi_pkg::*;

  logic        clock, reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic [1:0]  grant;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_24100029_axi_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .grant(grant), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    zero_inputs();
    @(negedge clock);
    reset = 0;
    #1;
  endtask

  task automatic set_req(input int m, input logic v, input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    if (m == 0) begin
      m0_arvalid = v; m0_araddr = a; m0_arlen = len; m0_arid = id; m0_arsize = SIZE_4B; m0_arburst = BURST_INCR;
    end else begin
      m1_arvalid = v; m1_araddr = a; m1_arlen = len; m1_arid = id; m1_arsize = SIZE_4B; m1_arburst = BURST_INCR;
    end
  endtask

  // Called in the IDLE cycle before the grant; finishes in the first DATA cycle.
  task automatic ar_grant(input int m, input logic [31:0] a, input string tag);
    @(negedge clock);
    s_arready = 1; #1;
    check({tag, "_grant"}, grant, (m == 0) ? 2'b01 : 2'b10);
    check({tag, "_s_arvalid"}, s_arvalid, 1);
    check({tag, "_s_araddr"}, s_araddr, a);
    check({tag, "_own_arready"}, (m == 0) ? m0_arready : m1_arready, 1);
    check({tag, "_oth_arready"}, (m == 0) ? m1_arready : m0_arready, 0);
    @(negedge clock);
    s_arready = 0;
    if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
    #1;
    check({tag, "_data_busy"}, busy, 1);
    check({tag, "_data_no_ar"}, s_arvalid, 0);
  endtask

  task automatic beat(input int m, input logic [31:0] d, input logic last, input logic [1:0] resp, input string tag);
    @(negedge clock);
    s_rvalid = 1; s_rdata = d; s_rlast = last; s_rresp = resp; s_rid = 4'(m + 3);
    m0_rready = 1; m1_rready = 1; #1;
    check({tag, "_s_rready"}, s_rready, 1);
    check({tag, "_rvalid"}, (m == 0) ? m0_rvalid : m1_rvalid, 1);
    check({tag, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, d);
    check({tag, "_rlast"}, (m == 0) ? m0_rlast : m1_rlast, last);
    check({tag, "_rresp"}, (m == 0) ? m0_rresp : m1_rresp, resp);
    check({tag, "_rid"}, (m == 0) ? m0_rid : m1_rid, 4'(m + 3));
    check({tag, "_other_rvalid"}, (m == 0) ? m1_rvalid : m0_rvalid, 0);
  endtask

  task automatic gap();
    @(negedge clock);
    s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0;
    #1;
  endtask

  // Random-phase model state: per-master pending request, owner (-1 = free), slave beat state.
  bit   [1:0]  mreq;
  logic [31:0] maddr [2];
  logic [7:0]  mlen  [2];
  logic [3:0]  mid   [2];
  int          mod_owner, last_served, sidx, slen;
  bit          ar_done, spend, sbv;
  logic [31:0] sdat;
  logic [1:0]  sresp;
  logic [3:0]  sid;
  int          n_txn [2];
  logic        own_rdy;

  initial begin
    reset = 1;
    zero_inputs();
    m0_arvalid = 1; s_arready = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF; m0_rready = 1;
    @(negedge clock); #1;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_m0_arready", m0_arready, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    zero_inputs();
    @(negedge clock);
    reset = 0;
    #1;

    // Single M0 read
    set_req(0, 1, 32'h3000_0000, 8'd0, 4'd1);
    #1 check("t1_arb_cycle_grant", grant, 2'b00);
    ar_grant(0, 32'h3000_0000, "t1");
    beat(0, 32'hDEAD_BEEF, 1, 2'b00, "t1_beat");
    gap();
    check("t1_busy_fall", busy, 0);
    check("t1_grant_fall", grant, 2'b00);

    // Simultaneous requests: M0 first, M1 after an idle cycle, then M0 again
    do_reset();
    set_req(0, 1, 32'h1000_0000, 8'd0, 4'd1);
    set_req(1, 1, 32'h8000_0010, 8'd0, 4'd2);
    #1 check("t2_arb_grant", grant, 2'b00);
    ar_grant(0, 32'h1000_0000, "t2_m0");
    beat(0, 32'h1111_1111, 1, 2'b00, "t2_m0_beat");
    gap();
    check("t2_idle_gap_grant", grant, 2'b00);
    check("t2_idle_m1_arready", m1_arready, 0);
    ar_grant(1, 32'h8000_0010, "t2_m1");
    beat(1, 32'h2222_2222, 1, 2'b00, "t2_m1_beat");
    gap();
    set_req(0, 1, 32'h1000_0100, 8'd0, 4'd1);
    set_req(1, 1, 32'h8000_0100, 8'd3, 4'd9);
    #1 check("t2_again_arb", grant, 2'b00);
    ar_grant(0, 32'h1000_0100, "t2_again");
    beat(0, 32'h3333_3333, 1, 2'b00, "t2_again_beat");
    gap();

    // M1 4-beat burst with gaps while M0 keeps requesting
    set_req(0, 1, 32'h1000_0200, 8'd0, 4'd1);
    ar_grant(1, 32'h8000_0100, "t3");
    for (int i = 1; i <= 4; i++) begin
      beat(1, 32'(i), (i == 4), 2'b00, "t3_beat");
      check("t3_m0_arready_beat", m0_arready, 0);
      if (i < 4) begin
        gap();
        check("t3_gap_m1_rvalid", m1_rvalid, 0);
        check("t3_gap_m0_arready", m0_arready, 0);
        check("t3_gap_busy", busy, 1);
      end
    end
    gap();
    check("t3_done_grant", grant, 2'b00);

    // Owner stalls R for three cycles
    ar_grant(0, 32'h1000_0200, "t4");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rlast = 1; s_rid = 4'd3; m0_rready = 0;
      #1;
      check("t4_stall_s_rready", s_rready, 0);
      check("t4_stall_rvalid", m0_rvalid, 1);
      check("t4_stall_busy", busy, 1);
    end
    beat(0, 32'hCAFE_F00D, 1, 2'b00, "t4_beat");
    gap();
    check("t4_no_dup_rvalid", m0_rvalid, 0);
    check("t4_busy_fall", busy, 0);

    // Error response on M0 with M1 pending
    set_req(0, 1, 32'h3000_0080, 8'd0, 4'd2);
    ar_grant(0, 32'h3000_0080, "t6_m0");
    set_req(1, 1, 32'h8000_0200, 8'd3, 4'd6);
    beat(0, 32'hBAD0_BAD0, 1, 2'b10, "t6_err");
    gap();
    check("t6_idle_grant", grant, 2'b00);
    check("t6_idle_busy", busy, 0);
    ar_grant(1, 32'h8000_0200, "t6_m1");

    // Reset in the middle of that M1 burst
    beat(1, 32'h1, 0, 2'b00, "t5_b1");
    beat(1, 32'h2, 0, 2'b00, "t5_b2");
    @(negedge clock);
    s_rvalid = 1; s_rdata = 32'h3; s_rlast = 0; reset = 1;
    #1;
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_s_rready", s_rready, 0);
    check("t5_rst_m1_rvalid", m1_rvalid, 0);
    @(negedge clock);
    reset = 0; s_rvalid = 0; s_rdata = '0;
    #1;
    check("t5_post_grant", grant, 2'b00);
    check("t5_post_m1_rvalid", m1_rvalid, 0);
    set_req(0, 1, 32'h3000_0040, 8'd0, 4'd1);
    ar_grant(0, 32'h3000_0040, "t5_m0");
    beat(0, 32'h5555_AAAA, 1, 2'b00, "t5_m0_beat");
    gap();
    check("t5_m0_busy_fall", busy, 0);

    // Randomized traffic against the transaction-level model
    do_reset();
    mreq = 2'b00; mod_owner = -1; last_served = 1; ar_done = 0;
    spend = 0; sbv = 0; sidx = 0; slen = 0; sid = '0; sdat = '0; sresp = '0;
    n_txn[0] = 0; n_txn[1] = 0;
    for (int k = 0; k < 2; k++) begin maddr[k] = '0; mlen[k] = '0; mid[k] = '0; end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++)
        if (!mreq[k] && $urandom_range(0, 3) == 0) begin
          mreq[k] = 1; maddr[k] = $urandom; mlen[k] = 8'($urandom_range(0, 3)); mid[k] = 4'($urandom_range(0, 15));
        end
      set_req(0, mreq[0], maddr[0], mlen[0], mid[0]);
      set_req(1, mreq[1], maddr[1], mlen[1], mid[1]);
      m0_rready = ($urandom_range(0, 2) != 0);
      m1_rready = ($urandom_range(0, 2) != 0);
      s_arready = 1'($urandom_range(0, 1));
      if (spend && !sbv && $urandom_range(0, 2) != 0) begin
        sbv = 1; sdat = $urandom; sresp = 2'($urandom_range(0, 3));
      end
      s_rvalid = sbv; s_rdata = sbv ? sdat : 32'h0; s_rresp = sresp;
      s_rlast = sbv && (sidx == slen); s_rid = sid;
      #1;
      own_rdy = (mod_owner == 1) ? m1_rready : m0_rready;
      check("rnd_grant", grant, (mod_owner < 0) ? 2'b00 : ((mod_owner == 0) ? 2'b01 : 2'b10));
      check("rnd_busy", busy, mod_owner >= 0);
      check("rnd_m0_arready", m0_arready, (mod_owner == 0 && !ar_done) ? s_arready : 1'b0);
      check("rnd_m1_arready", m1_arready, (mod_owner == 1 && !ar_done) ? s_arready : 1'b0);
      check("rnd_m0_rvalid", m0_rvalid, (mod_owner == 0 && ar_done) ? sbv : 1'b0);
      check("rnd_m1_rvalid", m1_rvalid, (mod_owner == 1 && ar_done) ? sbv : 1'b0);
      check("rnd_s_arvalid", s_arvalid, (mod_owner >= 0 && !ar_done) ? mreq[mod_owner] : 1'b0);
      check("rnd_s_rready", s_rready, (mod_owner >= 0 && ar_done) ? own_rdy : 1'b0);
      if (mod_owner >= 0 && !ar_done && mreq[mod_owner]) begin
        check("rnd_s_araddr", s_araddr, maddr[mod_owner]);
        check("rnd_s_arlen", s_arlen, mlen[mod_owner]);
        check("rnd_s_arid", s_arid, mid[mod_owner]);
      end
      if (mod_owner >= 0 && ar_done && sbv) begin
        check("rnd_rdata", (mod_owner == 0) ? m0_rdata : m1_rdata, sdat);
        check("rnd_rresp", (mod_owner == 0) ? m0_rresp : m1_rresp, sresp);
        check("rnd_rlast", (mod_owner == 0) ? m0_rlast : m1_rlast, sidx == slen);
        check("rnd_rid", (mod_owner == 0) ? m0_rid : m1_rid, sid);
      end
      if (mod_owner < 0) begin
        if (mreq == 2'b11) mod_owner = 1 - last_served;
        else if (mreq[0]) mod_owner = 0;
        else if (mreq[1]) mod_owner = 1;
        ar_done = 0;
      end else if (!ar_done) begin
        if (mreq[mod_owner] && s_arready) begin
          ar_done = 1; last_served = mod_owner; mreq[mod_owner] = 0;
          spend = 1; slen = int'(mlen[mod_owner]); sid = mid[mod_owner]; sidx = 0;
        end
      end else if (sbv && own_rdy) begin
        sbv = 0;
        if (sidx == slen) begin
          spend = 0; n_txn[mod_owner]++; mod_owner = -1; ar_done = 0;
        end else sidx++;
      end
    end
    check("rnd_m0_served", n_txn[0] > 20, 1);
    check("rnd_m1_served", n_txn[1] > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_axi_rd_arbiter.md
Name: ysyx_24100029_axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter (AR and R only).
- Shares the single memory/xbar read port between the instruction cache miss path (M0) and the LSU load path (M1).
- Grants whole transactions: AR handshake through the last R beat.
- Round-robin on simultaneous requests; the grant is locked for the whole burst.

Parameters:
- ADDR_WIDTH, 32, address width of all AR channels.
- DATA_WIDTH, 32, R data width.
- ID_WIDTH, 4, ARID/RID width; passed through unchanged.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_arvalid / m0_arready  in / out  1 / 1  icache AR handshake
- m0_araddr / m0_arid / m0_arlen / m0_arsize / m0_arburst  in  ADDR_WIDTH / ID_WIDTH / 8 / 3 / 2  icache AR payload
- m0_rvalid / m0_rready  out / in  1 / 1  icache R handshake
- m0_rdata / m0_rresp / m0_rlast / m0_rid  out  DATA_WIDTH / 2 / 1 / ID_WIDTH  icache R payload
- m1_*  same set as m0_*  LSU side
- s_arvalid / s_arready  out / in  1 / 1  slave AR handshake
- s_araddr / s_arid / s_arlen / s_arsize / s_arburst  out  same widths as m0  slave AR payload
- s_rvalid / s_rready  in / out  1 / 1  slave R handshake
- s_rdata / s_rresp / s_rlast / s_rid  in  same widths as m0  slave R payload
- grant  out  2  one-hot current owner; 00 = none
- busy  out  1  high while any transaction is owned

Behaviour:
- States:
  - IDLE: no owner.
  - ADDR: owner's AR is forwarded to the slave.
  - DATA: owner receives R beats.
- Registers: state, owner (1 bit), last_grant (1 bit).
- Reset (asynchronous, active-high):
  - state = IDLE, last_grant = 1, so M0 wins the first tie.
  - All outputs 0: grant=00, busy=0, s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0, all payload outputs 0.
- Reset asserted mid-transaction abandons the transaction; no beat is replayed after release.
- IDLE:
  - Only m0_arvalid → owner=0.
  - Only m1_arvalid → owner=1.
  - Both → owner = ~last_grant.
  - Transition to ADDR on the next edge, so arbitration costs one cycle.
  - In IDLE no arready and no rvalid is driven to either master.
- ADDR:
  - s_ar* = owner's ar* (combinational); s_arvalid = owner's arvalid.
  - Owner's arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: go to DATA, last_grant <= owner.
- DATA:
  - Owner's rvalid/rdata/rresp/rlast/rid = s_r*; s_rready = owner's rready.
  - Non-owner: rvalid=0, payload 0.
  - Leave for IDLE only on s_rvalid & s_rready & s_rlast. A beat with rlast=0 keeps the state; beat count is not checked.
- The AR handshake for the next transaction is never overlapped with R of the current one; exactly one outstanding transaction.
- A request arriving on the cycle the current transaction completes waits in IDLE one cycle. Minimum gap between transactions is 1 idle cycle.
- Back-pressure: owner rready=0 holds s_rready=0. The slave beat stays pending; the arbiter stores nothing.
- grant = one-hot owner in ADDR/DATA, else 00. busy = (state != IDLE).
- rresp is passed unchanged, including SLVERR/DECERR; errors do not alter sequencing.
- Requester contract: arvalid held until arready (AXI rule). If owner's arvalid drops in ADDR, stay in ADDR with s_arvalid=0.
- No combinational path from s_arready or s_rvalid to any state register except through the handshake terms above.

Decomposition:
- Shared package ysyx_24100029_axi_pkg:
  - arb_state_t enum {IDLE, ADDR, DATA}.
  - Localparams for AXI encodings: BURST_FIXED=2'b00, BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_4B=3'b010.
- One natural sub-module: ysyx_24100029_rr_pick.
  - Combinational two-way round-robin picker: req[1:0], last → gnt one-hot.
  - Reusable for a later write-channel arbiter.

Test Plan:
- Reset, then m0 only: araddr=0x3000_0000, arlen=0; slave returns rdata=0xDEAD_BEEF, rlast=1 → grant=01 one cycle after arvalid; m0_rvalid with 0xDEAD_BEEF; m1_rvalid stays 0; busy falls the cycle after rlast.
- Both request in the same cycle after reset → M0 granted first. M1 (araddr=0x8000_0010) is granted after M0's rlast plus 1 idle cycle. Next simultaneous request → M0 wins again (alternation).
- M1 burst arlen=3, INCR; slave sends 4 beats 0x1..0x4 with s_rvalid gaps; m0_arvalid high throughout → m0_arready stays 0 until M1's 4th beat completes; M1 receives 0x1..0x4 in order, rlast only on beat 4.
- Owner holds rready=0 for 3 cycles during DATA → s_rready=0 for those 3 cycles; beat delivered on the 4th cycle; no beat lost or duplicated.
- Assert reset during DATA of an M1 burst after 2 of 4 beats → next cycle grant=00, busy=0, s_rready=0; after release a fresh M0 request completes normally.
- Slave returns rresp=2'b10 on M0's single beat → m0_rresp=2'b10; arbiter returns to IDLE normally; a pending M1 request is granted next.
